gameport_paddles: RTL and testbench
===================================

# gameport_paddles

Parametrised Apple II game-port paddle timer: emulates the 558 quad one-shot behind PDL0..PDLn. A PTRIG strobe (C07x access) loads every channel with a duration derived from a signed 8-bit analog axis or a digital direction pair; each channel output stays high for that many CPU ticks. Sits beside the `apple2` core and drives the pdl bits of its GAMEPORT input, replacing the inline two-axis counter in the top level.

## Interface

Parameters:
- `N_CH`, default 4: number of paddle channels (1..4).
- `CNT_W`, default 13: counter width in bits; must hold `MAX_CNT`.
- `CENTER`, default 2800: count for axis value 0.
- `SCALE`, default 22: ticks per axis LSB.
- `MAX_CNT`, default 5650: clamp ceiling, also the digital "full" value.
- `RETRIGGER`, default 1: 1 = strobe reloads all channels; 0 = running channels ignore strobe (real 558).

Ports:
- `CLK_14M` in 1: 14.31818 MHz master clock.
- `reset` in 1: synchronous, active-high.
- `tick` in 1: one-cycle CPU-rate enable (rising edge of CLK_2M, generated outside).
- `pdl_strobe` in 1: PTRIG pulse from the core, any width ≥1 cycle.
- `digital` in 1: 1 = use `joy_dig`, 0 = use `joy_an`.
- `joy_an` in `8*N_CH`: signed axis per channel, channel i at `[8i+7:8i]`.
- `joy_dig` in `2*N_CH`: channel i `{pos,neg}` at `[2i+1:2i]`.
- `pdl` out `N_CH`: timer outputs, bit i = PDLi.
- `busy` out 1: OR of `pdl`.

## Operation

- Strobe capture: `pdl_strobe` high on any cycle sets `pend`. `pend` is consumed on the next `tick` cycle. A strobe coinciding with a `tick` is consumed on that same tick.
- Target per channel, computed at the consuming tick from the inputs on that cycle:
  - Analog: `t = CENTER + SCALE*signed(an)`, evaluated signed in `CNT_W+10` bits. Clamp `t<0` to 0 and `t>MAX_CNT` to `MAX_CNT`. No other rounding.
  - Digital: `neg` only gives 0; `pos` only gives `MAX_CNT`; neither or both gives `CENTER`.
- Per channel, on a tick:
  - If `pend`, and either `RETRIGGER=1` or `cnt==0`: `cnt <= t`.
  - Otherwise, if `cnt!=0`: `cnt <= cnt-1`.
  - A channel blocked by `RETRIGGER=0` decrements normally on that tick.
- `pdl[i]` is registered: equals `(cnt_next != 0)` and is updated only on tick cycles.
- Per-channel states: IDLE (`cnt==0`, pdl=0) and RUN (pdl=1).
  - IDLE→RUN on a load with `t>0`.
  - RUN→IDLE when decrement reaches 0.
  - RUN→RUN on retrigger.
  - A load with `t==0` stays IDLE.
- `busy` is the combinational OR of `pdl`.

## Timing

- Reset (on `CLK_14M` with `reset=1`): `cnt=0`, `pend=0`, `pdl=0`, `busy=0`. Reset overrides strobe and tick on the same cycle. Mid-count reset drops `pdl` on the next edge.
- Load latency: `pdl` rises on the edge of the first tick at or after the strobe.
- Width: a load of T keeps `pdl` high for exactly T tick periods (loaded at tick 0, falls at tick T).
- Inputs between ticks are ignored except for setting `pend`. Multiple strobes between ticks produce one load.
- Non-tick cycles hold all state.

## Structure

- Package `gameport_pkg`:
  - default constants `GP_CENTER`, `GP_SCALE`, `GP_MAX`;
  - function `gp_target(an, dig, digital)` returning the clamped `CNT_W` count.
- Sub-module `gameport_paddle_ch`: one counter, load/decrement logic and `pdl` flop.
- The top generates `N_CH` instances and holds the shared `pend` flop.

## Test plan

All cases use default parameters, tick every 7 cycles.

- Analog centre: `an=0`, strobe → pdl0 high exactly 2800 ticks, then 0.
- Analog extremes:
  - `an=+127` → 5594 ticks.
  - `an=-128` (−16 clamps to 0) → pdl stays 0, `busy` stays 0.
  - `SCALE=50`, `an=+127` → clamped to 5650 ticks.
- Digital mode:
  - ch1 `{pos,neg}=10` → 5650 ticks.
  - `01` → pdl never rises.
  - `11` → 2800 ticks.
- Retrigger: strobe, then at tick 1000 strobe again with `an=0`.
  - `RETRIGGER=1` → pdl0 falls at tick 3800.
  - `RETRIGGER=0` → falls at tick 2800.
- Strobe timing:
  - 1-cycle strobe between ticks is not lost.
  - Strobe coincident with a tick loads on that tick.
  - Three strobes inside one tick gap → single load.
- Reset mid-count at tick 500 → `pdl=0`, `busy=0` the next cycle. No output until a new strobe arrives after reset is released.

Source files
------------

// File: rtl/gameport_pkg.sv
// Shared constants, channel state encoding and the target-count function for
// the Apple II game-port paddle timer.
package gameport_pkg;

  localparam int GP_CENTER = 2800;
  localparam int GP_SCALE  = 22;
  localparam int GP_MAX    = 5650;
  localparam int GP_CNT_W  = 13;

  typedef enum logic {
    CH_IDLE = 1'b0,
    CH_RUN  = 1'b1
  } ch_state_e;

  // Returns the clamped load count. dig is {pos,neg}; analog math runs in
  // 32-bit signed, which covers any sensible CNT_W+10 range.
  function automatic int gp_target(input logic signed [7:0] an,
                                   input logic [1:0]        dig,
                                   input logic              digital,
                                   input int                center,
                                   input int                scale,
                                   input int                max_cnt);
    int t;
    if (digital) begin
      case (dig)
        2'b01:   t = 0;
        2'b10:   t = max_cnt;
        default: t = center;
      endcase
    end else begin
      t = center + scale * int'(an);
      if (t < 0) begin
        t = 0;
      end else if (t > max_cnt) begin
        t = max_cnt;
      end
    end
    return t;
  endfunction

endpackage

// File: rtl/gameport_paddles_if.sv
// Game-port paddle bundle: CPU-side controls in, 558-style timer outputs back.
interface gameport_paddles_if #(
  parameter int N_CH = 4
);
  logic                tick;
  logic                pdl_strobe;
  logic                digital;
  logic [8*N_CH-1:0]   joy_an;
  logic [2*N_CH-1:0]   joy_dig;
  logic [N_CH-1:0]     pdl;
  logic                busy;

  modport master (
    output tick, pdl_strobe, digital, joy_an, joy_dig,
    input  pdl, busy
  );

  modport slave (
    input  tick, pdl_strobe, digital, joy_an, joy_dig,
    output pdl, busy
  );
endinterface

// File: rtl/gameport_paddle_ch.sv
// One paddle one-shot: down-counter loaded from the axis target, pdl flop.
//   state   | meaning
//   CH_IDLE | cnt == 0, pdl low
//   CH_RUN  | cnt != 0, pdl high
module gameport_paddle_ch
  import gameport_pkg::*;
#(
  parameter int CNT_W     = GP_CNT_W,
  parameter int CENTER    = GP_CENTER,
  parameter int SCALE     = GP_SCALE,
  parameter int MAX_CNT   = GP_MAX,
  parameter int RETRIGGER = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tick,
  input  logic              load,
  input  logic              digital,
  input  logic signed [7:0] an,
  input  logic [1:0]        dig,
  output logic              pdl
);

  ch_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] target;
  logic             load_ok;

  always_comb begin
    target  = CNT_W'(gp_target(an, dig, digital, CENTER, SCALE, MAX_CNT));
    load_ok = load && ((RETRIGGER != 0) || (cnt_q == '0));
  end

  always_comb begin
    cnt_d   = cnt_q;
    state_d = state_q;
    if (tick) begin
      if (load_ok) begin
        cnt_d = target;
      end else if (cnt_q != '0) begin
        cnt_d = cnt_q - CNT_W'(1);
      end
      case (state_q)
        CH_IDLE: if (cnt_d != '0) state_d = CH_RUN;
        CH_RUN:  if (cnt_d == '0) state_d = CH_IDLE;
        default: state_d = CH_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q   <= '0;
      state_q <= CH_IDLE;
    end else begin
      cnt_q   <= cnt_d;
      state_q <= state_d;
    end
  end

  assign pdl = (state_q == CH_RUN);

endmodule

// File: rtl/gameport_paddles.sv
// Apple II game-port paddle timer: shared PTRIG capture plus N_CH one-shots
// clocked at CPU tick rate.
module gameport_paddles
  import gameport_pkg::*;
#(
  parameter int N_CH      = 4,
  parameter int CNT_W     = GP_CNT_W,
  parameter int CENTER    = GP_CENTER,
  parameter int SCALE     = GP_SCALE,
  parameter int MAX_CNT   = GP_MAX,
  parameter int RETRIGGER = 1
) (
  input  logic             CLK_14M,
  input  logic             reset,
  gameport_paddles_if.slave bus
);

  logic            pend_q, pend_d;
  logic            load;
  logic [N_CH-1:0] pdl_ch;

  // A strobe on the tick cycle itself is consumed by that tick.
  always_comb begin
    pend_d = pend_q | bus.pdl_strobe;
    load   = bus.tick & pend_d;
    if (bus.tick) begin
      pend_d = 1'b0;
    end
  end

  always_ff @(posedge CLK_14M) begin
    if (reset) begin
      pend_q <= 1'b0;
    end else begin
      pend_q <= pend_d;
    end
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    gameport_paddle_ch #(
      .CNT_W     (CNT_W),
      .CENTER    (CENTER),
      .SCALE     (SCALE),
      .MAX_CNT   (MAX_CNT),
      .RETRIGGER (RETRIGGER)
    ) u_ch (
      .clk     (CLK_14M),
      .reset   (reset),
      .tick    (bus.tick),
      .load    (load),
      .digital (bus.digital),
      .an      (bus.joy_an[8*i+7:8*i]),
      .dig     (bus.joy_dig[2*i+1:2*i]),
      .pdl     (pdl_ch[i])
    );
  end

  assign bus.pdl  = pdl_ch;
  assign bus.busy = |pdl_ch;

endmodule

// File: tb/tb_gameport_paddles.sv
// Bench for gameport_paddles: three DUTs (default, SCALE=50, RETRIGGER=0)
// share stimulus; pulse widths are scored against a queue of expected widths.
module tb_gameport_paddles;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic tick = 1'b0;
  logic strobe = 1'b0;
  logic dig_a = 1'b0, dig_s = 1'b0, dig_r = 1'b0;
  logic [31:0] an = '0;
  logic [7:0]  jd = '0;

  int checks = 0;
  int errors = 0;
  int tick_n = 0;
  int exp_q[12][$];
  int rise_t[12];
  int rises[12];
  logic [11:0] pdl_all;

  always #35 clk = ~clk;

  gameport_paddles_if #(.N_CH(4)) bus_a ();
  gameport_paddles_if #(.N_CH(4)) bus_s ();
  gameport_paddles_if #(.N_CH(4)) bus_r ();

  assign bus_a.tick = tick;  assign bus_s.tick = tick;  assign bus_r.tick = tick;
  assign bus_a.pdl_strobe = strobe;
  assign bus_s.pdl_strobe = strobe;
  assign bus_r.pdl_strobe = strobe;
  assign bus_a.digital = dig_a;  assign bus_s.digital = dig_s;  assign bus_r.digital = dig_r;
  assign bus_a.joy_an = an;  assign bus_s.joy_an = an;  assign bus_r.joy_an = an;
  assign bus_a.joy_dig = jd; assign bus_s.joy_dig = jd; assign bus_r.joy_dig = jd;
  assign pdl_all = {bus_r.pdl, bus_s.pdl, bus_a.pdl};

  gameport_paddles #(.N_CH(4)) dut_a (.CLK_14M(clk), .reset(reset), .bus(bus_a));
  gameport_paddles #(.N_CH(4), .SCALE(50)) dut_s (.CLK_14M(clk), .reset(reset), .bus(bus_s));
  gameport_paddles #(.N_CH(4), .RETRIGGER(0)) dut_r (.CLK_14M(clk), .reset(reset), .bus(bus_r));

  // tick high one cycle in seven, changed on the falling edge
  initial begin : tick_gen
    int ph;
    ph = 0;
    forever begin
      @(negedge clk);
      ph = (ph == 6) ? 0 : ph + 1;
      tick = (ph == 6);
    end
  end

  // Pulse monitor: measures each pdl pulse in ticks and scores it.
  initial begin : monitor
    logic [11:0] prev;
    logic [11:0] cur;
    int w;
    int e;
    prev = '0;
    for (int s = 0; s < 12; s++) begin
      rise_t[s] = 0;
      rises[s] = 0;
    end
    forever begin
      @(posedge clk);
      if (tick) tick_n++;
      #1;
      cur = pdl_all;
      for (int s = 0; s < 12; s++) begin
        if (cur[s] && !prev[s]) begin
          rise_t[s] = tick_n;
          rises[s]++;
        end
        if (!cur[s] && prev[s]) begin
          w = tick_n - rise_t[s];
          checks++;
          if (exp_q[s].size() == 0) begin
            errors++;
            $display("FAIL unexpected_pulse slot %0d: width %0d, no pulse expected", s, w);
          end else begin
            e = exp_q[s].pop_front();
            if (w !== e) begin
              errors++;
              $display("FAIL pulse_width slot %0d: got %0d ticks, expected %0d", s, w, e);
            end
          end
        end
      end
      prev = cur;
    end
  end

  function automatic logic [31:0] pack_an(int a0, int a1, int a2, int a3);
    logic [7:0] b0, b1, b2, b3;
    b0 = a0[7:0]; b1 = a1[7:0]; b2 = a2[7:0]; b3 = a3[7:0];
    return {b3, b2, b1, b0};
  endfunction

  task automatic wait_ticks(input int n);
    int stop;
    stop = tick_n + n;
    while (tick_n < stop) @(negedge clk);
  endtask

  // One-cycle strobe on a non-tick cycle; returns tick count at the strobe.
  task automatic strobe_between(output int at);
    do begin
      @(negedge clk); #1;
    end while (tick);
    strobe = 1'b1;
    at = tick_n;
    @(negedge clk); #1;
    strobe = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string name);
    int stop;
    stop = tick_n + budget;
    while ((pdl_all != '0) && (tick_n < stop)) @(negedge clk);
    #2;
    checks++;
    if (pdl_all != '0) begin
      errors++;
      $display("FAIL %s_timeout: pdl %h still busy after %0d ticks, expected 000", name, pdl_all, budget);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    strobe = 1'b1;
    repeat (4) @(negedge clk);
    #1;
    checks += 6;
    if (bus_a.pdl !== 4'b0) begin errors++; $display("FAIL reset_pdl_a: got %b expected 0000", bus_a.pdl); end
    if (bus_s.pdl !== 4'b0) begin errors++; $display("FAIL reset_pdl_s: got %b expected 0000", bus_s.pdl); end
    if (bus_r.pdl !== 4'b0) begin errors++; $display("FAIL reset_pdl_r: got %b expected 0000", bus_r.pdl); end
    if (bus_a.busy !== 1'b0) begin errors++; $display("FAIL reset_busy_a: got %b expected 0", bus_a.busy); end
    if (bus_s.busy !== 1'b0) begin errors++; $display("FAIL reset_busy_s: got %b expected 0", bus_s.busy); end
    if (bus_r.busy !== 1'b0) begin errors++; $display("FAIL reset_busy_r: got %b expected 0", bus_r.busy); end
    strobe = 1'b0;
    reset = 1'b0;
    wait_ticks(3);
    checks++;
    if (pdl_all !== 12'b0) begin errors++; $display("FAIL reset_strobe_ignored: got %h expected 000", pdl_all); end
  endtask

  // Default and SCALE=50 units analog, RETRIGGER=0 unit digital.
  task automatic test_analog_digital();
    int at;
    int r2, r6, r10;
    an = pack_an(0, 127, -128, -50);
    dig_a = 1'b0; dig_s = 1'b0; dig_r = 1'b1;
    jd = {2'b11, 2'b01, 2'b10, 2'b00};
    exp_q[0].push_back(2800); exp_q[1].push_back(5594); exp_q[3].push_back(1700);
    exp_q[4].push_back(2800); exp_q[5].push_back(5650); exp_q[7].push_back(300);
    exp_q[8].push_back(2800); exp_q[9].push_back(5650); exp_q[11].push_back(2800);
    r2 = rises[2]; r6 = rises[6]; r10 = rises[10];
    strobe_between(at);
    wait_ticks(2);
    #2;
    checks += 6;
    if (bus_a.pdl !== 4'b1011) begin errors++; $display("FAIL ad_pdl_a: got %b expected 1011", bus_a.pdl); end
    if (bus_s.pdl !== 4'b1011) begin errors++; $display("FAIL ad_pdl_s: got %b expected 1011", bus_s.pdl); end
    if (bus_r.pdl !== 4'b1011) begin errors++; $display("FAIL ad_pdl_r: got %b expected 1011", bus_r.pdl); end
    if (bus_a.busy !== 1'b1) begin errors++; $display("FAIL ad_busy_a: got %b expected 1", bus_a.busy); end
    if (bus_s.busy !== 1'b1) begin errors++; $display("FAIL ad_busy_s: got %b expected 1", bus_s.busy); end
    if (bus_r.busy !== 1'b1) begin errors++; $display("FAIL ad_busy_r: got %b expected 1", bus_r.busy); end
    wait_idle(6000, "ad");
    checks += 4;
    if (rises[2] !== r2) begin errors++; $display("FAIL ad_an_min_rose: got %0d rises expected %0d", rises[2], r2); end
    if (rises[6] !== r6) begin errors++; $display("FAIL ad_s50_min_rose: got %0d rises expected %0d", rises[6], r6); end
    if (rises[10] !== r10) begin errors++; $display("FAIL ad_dig_neg_rose: got %0d rises expected %0d", rises[10], r10); end
    if (bus_a.busy !== 1'b0) begin errors++; $display("FAIL ad_busy_end: got %b expected 0", bus_a.busy); end
  endtask

  task automatic test_all_zero();
    int at;
    int total;
    an = pack_an(-128, -128, -128, -128);
    dig_r = 1'b0;
    total = 0;
    for (int s = 0; s < 12; s++) total += rises[s];
    strobe_between(at);
    wait_ticks(3);
    #2;
    checks += 3;
    if ((bus_a.busy | bus_s.busy | bus_r.busy) !== 1'b0) begin
      errors++;
      $display("FAIL zero_busy: got %b%b%b expected 000", bus_a.busy, bus_s.busy, bus_r.busy);
    end
    if (pdl_all !== 12'b0) begin errors++; $display("FAIL zero_pdl: got %h expected 000", pdl_all); end
    for (int s = 0; s < 12; s++) total -= rises[s];
    if (total !== 0) begin errors++; $display("FAIL zero_rises: got %0d new rises expected 0", -total); end
  endtask

  task automatic test_retrigger();
    int s0, s1;
    an = pack_an(0, -128, -128, -128);
    exp_q[0].push_back(3800);
    exp_q[4].push_back(3800);
    exp_q[8].push_back(2800);
    strobe_between(s0);
    while (tick_n < s0 + 1000) @(negedge clk);
    strobe_between(s1);
    checks++;
    if (s1 !== s0 + 1000) begin errors++; $display("FAIL retrig_strobe_slot: got tick %0d expected %0d", s1, s0 + 1000); end
    wait_ticks(2);
    wait_idle(4000, "retrig");
  endtask

  task automatic test_strobe_timing();
    int at;
    int r0, r8;
    an = pack_an(-127, -128, -128, -128);
    // single-cycle strobe between ticks
    exp_q[0].push_back(6); exp_q[8].push_back(6);
    strobe_between(at);
    checks += 3;
    if (bus_a.pdl[0] !== 1'b0) begin errors++; $display("FAIL between_early: got %b expected 0", bus_a.pdl[0]); end
    wait_ticks(1);
    #2;
    if (bus_a.pdl[0] !== 1'b1) begin errors++; $display("FAIL between_lost_a: got %b expected 1", bus_a.pdl[0]); end
    if (bus_r.pdl[0] !== 1'b1) begin errors++; $display("FAIL between_lost_r: got %b expected 1", bus_r.pdl[0]); end
    wait_idle(20, "between");
    // strobe on the tick cycle itself
    exp_q[0].push_back(6); exp_q[8].push_back(6);
    do begin
      @(negedge clk); #1;
    end while (!tick);
    strobe = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (bus_a.pdl[0] !== 1'b1) begin errors++; $display("FAIL coincident_load: got %b expected 1", bus_a.pdl[0]); end
    @(negedge clk); #1;
    strobe = 1'b0;
    wait_idle(20, "coincident");
    // three strobes in one tick gap
    exp_q[0].push_back(6); exp_q[8].push_back(6);
    r0 = rises[0]; r8 = rises[8];
    do begin
      @(negedge clk); #1;
    end while (!tick);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk); #1;
      strobe = (k % 2 == 0);
    end
    @(negedge clk); #1;
    strobe = 1'b0;
    wait_ticks(2);
    wait_idle(20, "triple");
    checks += 2;
    if (rises[0] !== r0 + 1) begin errors++; $display("FAIL triple_loads_a: got %0d rises expected %0d", rises[0] - r0, 1); end
    if (rises[8] !== r8 + 1) begin errors++; $display("FAIL triple_loads_r: got %0d rises expected %0d", rises[8] - r8, 1); end
  endtask

  task automatic test_reset_midcount();
    int at;
    int total;
    an = pack_an(0, -128, -128, -128);
    exp_q[0].push_back(500); exp_q[4].push_back(500); exp_q[8].push_back(500);
    strobe_between(at);
    while (tick_n < at + 501) @(negedge clk);
    do begin
      @(negedge clk); #1;
    end while (tick);
    reset = 1'b1;
    strobe = 1'b1;
    @(posedge clk); #1;
    checks += 2;
    if (pdl_all !== 12'b0) begin errors++; $display("FAIL midreset_pdl: got %h expected 000", pdl_all); end
    if ((bus_a.busy | bus_s.busy | bus_r.busy) !== 1'b0) begin errors++; $display("FAIL midreset_busy: got 1 expected 0"); end
    @(negedge clk); #1;
    reset = 1'b0;
    strobe = 1'b0;
    total = 0;
    for (int s = 0; s < 12; s++) total += rises[s];
    wait_ticks(20);
    for (int s = 0; s < 12; s++) total -= rises[s];
    checks++;
    if (total !== 0) begin errors++; $display("FAIL midreset_quiet: got %0d rises expected 0", -total); end
    an = pack_an(-127, -128, -128, -128);
    exp_q[0].push_back(6); exp_q[8].push_back(6);
    strobe_between(at);
    wait_ticks(2);
    #2;
    checks++;
    if (bus_a.pdl !== 4'b0001) begin errors++; $display("FAIL midreset_recover: got %b expected 0001", bus_a.pdl); end
    wait_idle(20, "recover");
  endtask

  task automatic test_drain();
    for (int s = 0; s < 12; s++) begin
      checks++;
      if (exp_q[s].size() !== 0) begin
        errors++;
        $display("FAIL missing_pulse slot %0d: got %0d pending expected 0", s, exp_q[s].size());
      end
    end
  endtask

  initial begin
    test_reset();
    test_analog_digital();
    test_all_zero();
    test_retrigger();
    test_strobe_timing();
    test_reset_midcount();
    test_drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
